// File: rtl/imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// imem_fetch_ctrl
//
// Fetch sequencer for a small word-indexed instruction ROM. It owns the fetch
// PC, drives the ROM address combinationally from it, and captures each fetched
// word, together with its PC, into a one-entry output buffer. Decode takes
// entries from that buffer over a valid/ready handshake. The block also handles
// branch redirects, stops at a self-looping halt word, and latches a sticky
// fault on any misaligned or out-of-range fetch address.
//
// Ports
//   i_clk          clock; all state changes on the rising edge
//   i_reset        synchronous, active-low reset
//   o_imem_addr    ROM word address, taken from the fetch PC (combinational)
//   i_imem_q       ROM read data, valid in the same cycle
//   i_redirect     one-cycle pulse for a taken branch or flush
//   i_redirect_pc  new fetch PC, sampled while i_redirect is high
//   o_out_valid    the output buffer holds a fetched instruction
//   i_out_ready    decode accepts the buffered instruction this cycle
//   o_out_instr    buffered instruction
//   o_out_pc       PC of the buffered instruction
//   o_halted       halt word fetched; fetching has stopped
//   o_fault        sticky flag for a misaligned or out-of-range fetch
// -----------------------------------------------------------------------------
module imem_fetch_ctrl #(
  parameter int           N         = 64,
  parameter int           IW        = 32,
  parameter int           AW        = 6,
  parameter logic [N-1:0] RESET_PC  = '0,
  parameter logic [IW-1:0] HALT_WORD = 32'hb400001f
) (
  input  logic          i_clk,
  input  logic          i_reset,
  output logic [AW-1:0] o_imem_addr,
  input  logic [IW-1:0] i_imem_q,
  input  logic          i_redirect,
  input  logic [N-1:0]  i_redirect_pc,
  output logic          o_out_valid,
  input  logic          i_out_ready,
  output logic [IW-1:0] o_out_instr,
  output logic [N-1:0]  o_out_pc,
  output logic          o_halted,
  output logic          o_fault
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HALT  = 2'd1,
    FAULT = 2'd2
  } fetchState_t;

  fetchState_t   r_state;
  logic [N-1:0]  r_fetchPc;
  logic          r_outValid;
  logic [IW-1:0] r_outInstr;
  logic [N-1:0]  r_outPc;
  logic          r_halted;
  logic          r_fault;

  logic          w_pcLegal;
  logic          w_bufferFree;
  logic          w_load;
  logic          w_redirectTaken;
  logic          w_handshake;

  // The ROM address is the word index of the fetch PC. It is never wrapped:
  // a PC past the top of the ROM is caught by the legality check instead.
  assign o_imem_addr = r_fetchPc[AW+1:2];

  // A fetch PC is usable only when word aligned and inside the ROM. Any upper
  // bit set above the word-index field means the PC is past the last word.
  assign w_pcLegal = (r_fetchPc[1:0] == 2'b00) && (r_fetchPc[N-1:AW+2] == '0);

  // The buffer can take a new word when it is empty or being drained now, so
  // a steady stream with ready held high moves one instruction per cycle.
  assign w_bufferFree = !r_outValid || i_out_ready;
  assign w_handshake  = r_outValid && i_out_ready;

  // A redirect only takes effect outside FAULT; in FAULT it is ignored and
  // the buffer keeps draining as if no redirect had arrived.
  assign w_redirectTaken = i_redirect && (r_state != FAULT);

  assign w_load = (r_state == FETCH) && !i_redirect && w_bufferFree && w_pcLegal;

  // Single sequential block for the fetch state machine and every registered
  // output. Reset beats everything, including a buffer held mid-stall. A taken
  // redirect comes next: it squashes the buffer (a coincident handshake still
  // counts as done) and restarts fetching at the new PC on the following edge,
  // without checking that PC here. Otherwise an illegal PC in FETCH moves to
  // FAULT, a load captures the ROM word and may enter HALT, and a handshake
  // with no load simply empties the buffer.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state    <= FETCH;
      r_fetchPc  <= RESET_PC;
      r_outValid <= 1'b0;
      r_outInstr <= '0;
      r_outPc    <= '0;
      r_halted   <= 1'b0;
      r_fault    <= 1'b0;
    end else if (w_redirectTaken) begin
      r_state    <= FETCH;
      r_fetchPc  <= i_redirect_pc;
      r_outValid <= 1'b0;
      r_halted   <= 1'b0;
    end else begin
      if ((r_state == FETCH) && !w_pcLegal) begin
        r_state <= FAULT;
        r_fault <= 1'b1;
      end
      if (w_load) begin
        r_outInstr <= i_imem_q;
        r_outPc    <= r_fetchPc;
        r_outValid <= 1'b1;
        r_fetchPc  <= r_fetchPc + N'(4);
        // The halt word is still handed to decode once; fetching stops after it.
        if (i_imem_q == HALT_WORD) begin
          r_state  <= HALT;
          r_halted <= 1'b1;
        end
      end else if (w_handshake) begin
        r_outValid <= 1'b0;
      end
    end
  end

  assign o_out_valid = r_outValid;
  assign o_out_instr = r_outInstr;
  assign o_out_pc    = r_outPc;
  assign o_halted    = r_halted;
  assign o_fault     = r_fault;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_ctrl
//
// Directed bench for imem_fetch_ctrl. A 64-word ROM model answers the DUT's
// address combinationally. Each scenario task drives its inputs right after a
// rising edge and compares outputs at that same point, away from the edge.
// -----------------------------------------------------------------------------
module tb_imem_fetch_ctrl;

  localparam int N  = 64;
  localparam int IW = 32;
  localparam int AW = 6;
  localparam logic [IW-1:0] HALT = 32'hb400001f;

  logic          clk;
  logic          reset;
  logic [AW-1:0] imemAddr;
  logic [IW-1:0] imemQ;
  logic          redirect;
  logic [N-1:0]  redirectPc;
  logic          outValid;
  logic          outReady;
  logic [IW-1:0] outInstr;
  logic [N-1:0]  outPc;
  logic          halted;
  logic          fault;

  logic [IW-1:0] rom [64];

  int nChecks = 0;
  int nFails  = 0;

  imem_fetch_ctrl #(.N(N), .IW(IW), .AW(AW)) dut (
    .i_clk         (clk),
    .i_reset       (reset),
    .o_imem_addr   (imemAddr),
    .i_imem_q      (imemQ),
    .i_redirect    (redirect),
    .i_redirect_pc (redirectPc),
    .o_out_valid   (outValid),
    .i_out_ready   (outReady),
    .o_out_instr   (outInstr),
    .o_out_pc      (outPc),
    .o_halted      (halted),
    .o_fault       (fault)
  );

  assign imemQ = rom[imemAddr];

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle a little past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse a redirect across exactly one rising edge.
  task automatic applyStimulus(input logic [N-1:0] pc);
    redirect   = 1'b1;
    redirectPc = pc;
    tick();
    redirect   = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b0;
    outReady = 1'b1;
    redirect = 1'b0;
    redirectPc = '0;
    for (int i = 0; i < 3; i++) tick();
    nChecks++;
    if (outValid !== 1'b0 || outPc !== 64'h0 || outInstr !== 32'h0 || halted !== 1'b0 || fault !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL reset_state: valid=%b pc=%h instr=%h halted=%b fault=%b, required 0/0/0/0/0", outValid, outPc, outInstr, halted, fault);
    end
    nChecks++;
    if (imemAddr !== 6'd0) begin
      nFails++;
      $display("[TB] FAIL reset_addr: got %0d, required 0", imemAddr);
    end
    reset = 1'b1;
  endtask

  task automatic test_stream();
    logic [N-1:0]  expPc    [3];
    logic [IW-1:0] expInstr [3];
    expPc[0] = 64'h0; expInstr[0] = 32'hf8000001;
    expPc[1] = 64'h4; expInstr[1] = 32'hf8008002;
    expPc[2] = 64'h8; expInstr[2] = 32'hf8000203;
    for (int i = 0; i < 3; i++) begin
      tick();
      nChecks++;
      if (outValid !== 1'b1 || outPc !== expPc[i] || outInstr !== expInstr[i]) begin
        nFails++;
        $display("[TB] FAIL stream_%0d: valid=%b pc=%h instr=%h, required 1 pc=%h instr=%h", i, outValid, outPc, outInstr, expPc[i], expInstr[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    outReady = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      nChecks++;
      if (outValid !== 1'b1 || outPc !== 64'h8 || outInstr !== 32'hf8000203 || imemAddr !== 6'd3) begin
        nFails++;
        $display("[TB] FAIL stall_%0d: valid=%b pc=%h instr=%h addr=%0d, required 1 pc=8 instr=f8000203 addr=3", i, outValid, outPc, outInstr, imemAddr);
      end
    end
    outReady = 1'b1;
    tick();
    nChecks++;
    if (outValid !== 1'b1 || outPc !== 64'hc || outInstr !== 32'h8b050083) begin
      nFails++;
      $display("[TB] FAIL stall_release: valid=%b pc=%h instr=%h, required 1 pc=c instr=8b050083", outValid, outPc, outInstr);
    end
  endtask

  task automatic test_redirect();
    applyStimulus(64'h74);
    nChecks++;
    if (outValid !== 1'b0 || imemAddr !== 6'h1d) begin
      nFails++;
      $display("[TB] FAIL redirect_squash: valid=%b addr=%h, required 0 addr=1d", outValid, imemAddr);
    end
    tick();
    nChecks++;
    if (outValid !== 1'b1 || outPc !== 64'h74 || outInstr !== 32'hb4000040) begin
      nFails++;
      $display("[TB] FAIL redirect_target: valid=%b pc=%h instr=%h, required 1 pc=74 instr=b4000040", outValid, outPc, outInstr);
    end
  endtask

  task automatic test_halt();
    int badSeq;
    applyStimulus(64'h0);
    badSeq = 0;
    for (int i = 0; i < 47; i++) begin
      tick();
      nChecks++;
      if (outValid !== 1'b1 || outPc !== 64'(4 * i) || outInstr !== rom[i]) begin
        nFails++;
        $display("[TB] FAIL freerun_%0d: valid=%b pc=%h instr=%h, required 1 pc=%h instr=%h", i, outValid, outPc, outInstr, 64'(4 * i), rom[i]);
      end
    end
    nChecks++;
    if (halted !== 1'b1 || outInstr !== HALT) begin
      nFails++;
      $display("[TB] FAIL halt_flag: halted=%b instr=%h, required 1 instr=%h", halted, outInstr, HALT);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      nChecks++;
      if (outValid !== 1'b0 || halted !== 1'b1) begin
        nFails++;
        $display("[TB] FAIL halt_idle_%0d: valid=%b halted=%b, required 0 1", i, outValid, halted);
      end
    end
    applyStimulus(64'h0);
    nChecks++;
    if (halted !== 1'b0 || outValid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL halt_exit: halted=%b valid=%b, required 0 0", halted, outValid);
    end
    tick();
    nChecks++;
    if (outValid !== 1'b1 || outPc !== 64'h0 || outInstr !== 32'hf8000001) begin
      nFails++;
      $display("[TB] FAIL halt_resume: valid=%b pc=%h instr=%h, required 1 pc=0 instr=f8000001", outValid, outPc, outInstr);
    end
  endtask

  task automatic test_pc_wrap();
    applyStimulus(64'hfc);
    tick();
    nChecks++;
    if (outValid !== 1'b1 || outPc !== 64'hfc || outInstr !== rom[63] || fault !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL wrap_last: valid=%b pc=%h instr=%h fault=%b, required 1 pc=fc instr=%h fault=0", outValid, outPc, outInstr, fault, rom[63]);
    end
    tick();
    nChecks++;
    if (fault !== 1'b1 || outValid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL wrap_fault: fault=%b valid=%b, required 1 0", fault, outValid);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_fault();
    applyStimulus(64'h102);
    nChecks++;
    if (fault !== 1'b0 || outValid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL misalign_accept: fault=%b valid=%b, required 0 0", fault, outValid);
    end
    tick();
    nChecks++;
    if (fault !== 1'b1 || outValid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL misalign_fault: fault=%b valid=%b, required 1 0", fault, outValid);
    end
    applyStimulus(64'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      nChecks++;
      if (fault !== 1'b1 || outValid !== 1'b0) begin
        nFails++;
        $display("[TB] FAIL fault_sticky_%0d: fault=%b valid=%b, required 1 0", i, fault, outValid);
      end
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    nChecks++;
    if (fault !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL fault_clear: fault=%b, required 0", fault);
    end
    applyStimulus(64'h100);
    tick();
    nChecks++;
    if (fault !== 1'b1 || outValid !== 1'b0) begin
      nFails++;
      $display("[TB] FAIL range_fault: fault=%b valid=%b, required 1 0", fault, outValid);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset_in_stall();
    tick();
    tick();
    outReady = 1'b0;
    tick();
    nChecks++;
    if (outValid !== 1'b1 || outPc !== 64'h4) begin
      nFails++;
      $display("[TB] FAIL pre_reset_stall: valid=%b pc=%h, required 1 pc=4", outValid, outPc);
    end
    reset = 1'b0;
    tick();
    nChecks++;
    if (outValid !== 1'b0 || outPc !== 64'h0 || outInstr !== 32'h0) begin
      nFails++;
      $display("[TB] FAIL stall_reset: valid=%b pc=%h instr=%h, required 0 0 0", outValid, outPc, outInstr);
    end
    reset    = 1'b1;
    outReady = 1'b1;
    tick();
    nChecks++;
    if (outValid !== 1'b1 || outPc !== 64'h0 || outInstr !== 32'hf8000001) begin
      nFails++;
      $display("[TB] FAIL restart: valid=%b pc=%h instr=%h, required 1 pc=0 instr=f8000001", outValid, outPc, outInstr);
    end
  endtask

  // ROM image: filler words that never match the halt word, a few known
  // instructions at the front, the branch target at 0x74 and halt at 0xB8.
  initial begin
    for (int i = 0; i < 64; i++) rom[i] = 32'h91000000 | 32'(i);
    rom[0]  = 32'hf8000001;
    rom[1]  = 32'hf8008002;
    rom[2]  = 32'hf8000203;
    rom[3]  = 32'h8b050083;
    rom[29] = 32'hb4000040;
    rom[46] = HALT;

    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_pc_wrap();
    test_fault();
    test_reset_in_stall();

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
